mac_counter: RTL and testbench
==============================

# mac_counter

Free-running, enable-gated up-counter for the multiply-add accumulator datapath. It sequences accumulation steps and provides the current step index to the datapath and control logic. It also flags the terminal count and wrap-around, so control logic can close an accumulation window without its own comparator. Fully synchronous, single clock domain.

## Interface
Parameters:
- WIDTH_CNT, default 5: counter width in bits; legal range 1..32.

Ports:
- clk  input  1: clock; all state updates on rising edge.
- cnt_rst_ni  input  1: one clock; reset is synchronous and active-low. Sampled only on the rising edge of clk; 0 forces reset.
- cnt_en_i  input  1: count enable; 1 advances the count by one per cycle.
- cnt_o  output  WIDTH_CNT: current count, driven directly from a register.
- cnt_max_o  output  1: combinational from the register; 1 when cnt_o == 2^WIDTH_CNT-1.
- cnt_wrap_o  output  1: registered one-cycle pulse, 1 in the cycle after the count wrapped from all-ones to 0.

## Operation
- Reset (cnt_rst_ni = 0 at a rising edge): cnt_o <= 0 and cnt_wrap_o <= 0. cnt_max_o reads 0 after reset.
- Reset has priority over enable. If reset and enable are both active in the same cycle, the result is reset.
- Enable (reset inactive, cnt_en_i = 1): cnt_o <= cnt_o + 1, modulo 2^WIDTH_CNT.
- Hold (reset inactive, cnt_en_i = 0): cnt_o keeps its value and cnt_wrap_o <= 0.
- Wrap: on an enabled edge with cnt_o = all-ones, cnt_o <= 0 and cnt_wrap_o <= 1. On every other edge cnt_wrap_o <= 0.
- No saturation, no down-count and no load. The counter is unsigned and wraps silently.
- Mid-count reset: the count is discarded immediately. After reset deasserts, counting resumes from 0 on the next enabled edge.
- Outputs never go X or Z once the first reset edge has occurred. Before the first reset, the register value is undefined.

## Timing
- Latency: enable seen at edge N gives cnt_o incremented after edge N. Counting is one increment per enabled cycle, with no gaps.
- cnt_max_o follows cnt_o combinationally, in the same cycle.
- cnt_wrap_o goes high in the same cycle that cnt_o reads 0 after a wrap, and stays high for exactly one cycle.
- Reset takes effect at the first rising edge where cnt_rst_ni = 0. Release takes effect at the first edge where it reads 1.
- Full period with enable held continuously: 2^WIDTH_CNT cycles. For the default width this is 32 cycles.

## Structure
- Shared package mac_pkg holds:
  - the default counter width constant (CNT_WIDTH_DEF = 5),
  - a typedef for the count type, used by the accumulator control.
- No sub-module is needed. The next-state logic, register and flag decode sit in one module.
- Parameter check: an elaboration-time assertion fires when WIDTH_CNT < 1 or WIDTH_CNT > 32.

## Test plan
- Reset hold: cnt_rst_ni = 0 and cnt_en_i = 0 for 10 cycles -> cnt_o = 0, cnt_max_o = 0, cnt_wrap_o = 0 every cycle.
- Idle after release: release reset with cnt_en_i = 0 for 1 cycle -> cnt_o stays 0.
- Counting: enable for 10 cycles -> cnt_o reads 1..10 on successive cycles.
- Mid-count reset with enable still 1:
  - pulse cnt_rst_ni = 0 for 1 cycle at cnt_o = 10 -> cnt_o = 0 the next cycle,
  - then 1, 2, ... with no gap after release.
- Wrap: enable continuously for 100 cycles, default width ->
  - cnt_max_o high exactly when cnt_o = 31,
  - cnt_o goes 31 -> 0,
  - cnt_wrap_o pulses for one cycle at each wrap, three times in total.
- Enable gating: toggle cnt_en_i 1,0,1,0 starting from cnt_o = 5 -> cnt_o reads 6, 6, 7, 7. At WIDTH_CNT = 1, cnt_o alternates 0, 1, 0 and cnt_wrap_o pulses every second enabled cycle.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-add accumulator datapath: default step-counter
// width and the count type used by the accumulator control.
package mac_pkg;

    localparam int CNT_WIDTH_DEF = 5;

    typedef logic [CNT_WIDTH_DEF-1:0] cnt_t;

endpackage

// File: rtl/mac_counter.sv
// Enable-gated free-running up-counter that sequences accumulation steps and flags
// terminal count and wrap-around for the accumulator control.
module mac_counter
    import mac_pkg::*;
#(
    parameter int WIDTH_CNT = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 cnt_rst_ni,
    input  logic                 cnt_en_i,
    output logic [WIDTH_CNT-1:0] cnt_o,
    output logic                 cnt_max_o,
    output logic                 cnt_wrap_o
);

    if (WIDTH_CNT < 1 || WIDTH_CNT > 32) begin : gen_width_check
        $fatal(1, "mac_counter: WIDTH_CNT must be within 1..32");
    end

    logic [WIDTH_CNT-1:0] cnt_q, cnt_d;
    logic                 wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (cnt_en_i) begin
            cnt_d  = cnt_q + WIDTH_CNT'(1);
            // Wrap flag is set on the same edge that rolls all-ones over to zero.
            wrap_d = &cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!cnt_rst_ni) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_max_o  = &cnt_q;
    assign cnt_wrap_o = wrap_q;

endmodule

// File: tb/tb_mac_counter.sv
// Scoreboard bench for mac_counter at the default width and at width 1, sharing stimulus.
module tb_mac_counter;

    logic       clk;
    logic       cnt_rst_ni;
    logic       cnt_en_i;
    logic [4:0] cnt_o;
    logic       cnt_max_o;
    logic       cnt_wrap_o;
    logic [0:0] cnt1_o;
    logic       cnt1_max_o;
    logic       cnt1_wrap_o;

    mac_counter u_dut (
        .clk        (clk),
        .cnt_rst_ni (cnt_rst_ni),
        .cnt_en_i   (cnt_en_i),
        .cnt_o      (cnt_o),
        .cnt_max_o  (cnt_max_o),
        .cnt_wrap_o (cnt_wrap_o)
    );

    mac_counter #(
        .WIDTH_CNT (1)
    ) u_dut_w1 (
        .clk        (clk),
        .cnt_rst_ni (cnt_rst_ni),
        .cnt_en_i   (cnt_en_i),
        .cnt_o      (cnt1_o),
        .cnt_max_o  (cnt1_max_o),
        .cnt_wrap_o (cnt1_wrap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned cnt;
        bit          max;
        bit          wrap;
        int unsigned cnt1;
        bit          max1;
        bit          wrap1;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned m_cnt    = 0;
    bit          m_wrap   = 0;
    int unsigned m_cnt1   = 0;
    bit          m_wrap1  = 0;
    int unsigned wraps    = 0;
    int unsigned wraps1   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of stimulus: update the reference model, push the expectation,
    // then compare the DUT outputs one time unit after the edge.
    task automatic step(input bit rst_n, input bit en);
        exp_t e;
        exp_t o;
        if (!rst_n) begin
            m_cnt   = 0;
            m_wrap  = 0;
            m_cnt1  = 0;
            m_wrap1 = 0;
        end else if (en) begin
            m_wrap  = (m_cnt == 31);
            m_cnt   = (m_cnt + 1) % 32;
            m_wrap1 = (m_cnt1 == 1);
            m_cnt1  = (m_cnt1 + 1) % 2;
        end else begin
            m_wrap  = 0;
            m_wrap1 = 0;
        end
        e.cnt   = m_cnt;
        e.max   = (m_cnt == 31);
        e.wrap  = m_wrap;
        e.cnt1  = m_cnt1;
        e.max1  = (m_cnt1 == 1);
        e.wrap1 = m_wrap1;
        exp_q.push_back(e);
        cnt_rst_ni = rst_n;
        cnt_en_i   = en;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            o = exp_q.pop_front();
            check_eq("cnt", 32'(cnt_o), o.cnt);
            check_eq("max", 32'(cnt_max_o), 32'(o.max));
            check_eq("wrap", 32'(cnt_wrap_o), 32'(o.wrap));
            check_eq("cnt_w1", 32'(cnt1_o), o.cnt1);
            check_eq("max_w1", 32'(cnt1_max_o), 32'(o.max1));
            check_eq("wrap_w1", 32'(cnt1_wrap_o), 32'(o.wrap1));
        end
        if (cnt_wrap_o === 1'b1) wraps++;
        if (cnt1_wrap_o === 1'b1) wraps1++;
    endtask

    initial begin
        cnt_rst_ni = 1'b0;
        cnt_en_i   = 1'b0;

        // Reset hold
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        // Idle after release
        step(1'b1, 1'b0);
        check_eq("idle_hold", 32'(cnt_o), 32'd0);

        // Counting 1..10
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1);
            check_eq("count_seq", 32'(cnt_o), 32'(i));
        end

        // Mid-count reset with enable held high
        step(1'b0, 1'b1);
        check_eq("mid_rst", 32'(cnt_o), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1);
            check_eq("resume_seq", 32'(cnt_o), 32'(i));
        end

        // Wrap: 100 enabled cycles from zero
        step(1'b0, 1'b0);
        wraps  = 0;
        wraps1 = 0;
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
        check_eq("wrap_count", wraps, 32'd3);
        check_eq("wrap_count_w1", wraps1, 32'd50);
        check_eq("cnt_after_100", 32'(cnt_o), 32'd4);

        // Enable gating from cnt = 5
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        check_eq("gate_start", 32'(cnt_o), 32'd5);
        step(1'b1, 1'b1);
        check_eq("gate_1", 32'(cnt_o), 32'd6);
        step(1'b1, 1'b0);
        check_eq("gate_2", 32'(cnt_o), 32'd6);
        step(1'b1, 1'b1);
        check_eq("gate_3", 32'(cnt_o), 32'd7);
        step(1'b1, 1'b0);
        check_eq("gate_4", 32'(cnt_o), 32'd7);
        check_eq("gate_wrap_low", 32'(cnt_wrap_o), 32'd0);

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
